// File: rtl/fip_32_seq_div.sv
// Sequential signed fixed-point divider (Q(WIDTH-INT_SHIFT).INT_SHIFT).
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by sign fix-up and saturation into WIDTH bits. A zero divisor
// skips the iteration and returns a signed full-scale value with
// o_underflow set.
module fip_32_seq_div #(
    parameter int WIDTH     = 32,
    parameter int INT_SHIFT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_overflow,
    output logic             o_underflow
);

    // Numerator is |dividend| << INT_SHIFT; one iteration per numerator bit.
    localparam int NUM = WIDTH + INT_SHIFT;
    localparam int CW  = $clog2(NUM + 1);

    // Largest representable magnitudes for negative / positive results.
    localparam logic [NUM-1:0]   MAG_NEG = {{(NUM-1){1'b0}}, 1'b1} << (WIDTH - 1);
    localparam logic [NUM-1:0]   MAG_POS = MAG_NEG - 1'b1;
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic               neg_q, neg_d;
    logic [NUM-1:0]     num_q, num_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [NUM-1:0]     quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    // Datapath helpers, valid in every state.
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     trial;
    logic               take;
    logic [WIDTH-1:0]   rem_next;
    logic [NUM-1:0]     quo_next;
    logic [WIDTH-1:0]   quo_lo;

    // Next-state logic: operand capture, one restoring step per CALC
    // cycle, and sign/saturation applied on the final step.
    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        num_d       = num_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Magnitudes are unsigned WIDTH bits, so the most negative
        // operand maps to 2^(WIDTH-1) without wrapping.
        mag_a    = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
        mag_b    = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

        // Remainder stays below the divisor, so one extra bit covers the shift.
        trial    = {rem_q, num_q[NUM-1]};
        take     = (trial >= {1'b0, div_q});
        rem_next = take ? (trial[WIDTH-1:0] - div_q) : trial[WIDTH-1:0];
        quo_next = {quo_q[NUM-2:0], take};
        quo_lo   = quo_next[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    neg_d = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                    if (i_divisor == '0) begin
                        quotient_d  = i_dividend[WIDTH-1] ? Q_MIN : Q_MAX;
                        overflow_d  = 1'b0;
                        underflow_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        num_d   = NUM'(mag_a) << INT_SHIFT;
                        div_d   = mag_b;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                num_d = num_q << 1;
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NUM - 1)) begin
                    state_d     = DONE;
                    underflow_d = 1'b0;
                    if (neg_q) begin
                        overflow_d = (quo_next > MAG_NEG);
                        quotient_d = (quo_next > MAG_NEG) ? Q_MIN : -quo_lo;
                    end else begin
                        overflow_d = (quo_next > MAG_POS);
                        quotient_d = (quo_next > MAG_POS) ? Q_MAX : quo_lo;
                    end
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            num_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            num_q       <= num_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_quotient  = quotient_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule
